// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit type, digit limits and validity helper for the N-digit BCD counter.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic is_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with parallel load and carry/borrow chaining.
// cout is combinational so a whole digit chain ripples within one cycle.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  bcd_digit_t ld_digit,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  assign cout = cin & (up ? (digit == BCD_MAX) : (digit == BCD_MIN));

  // Step by one in the selected direction, wrapping within 0..9.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= ld_digit;
    end else if (en && cin) begin
      if (up) digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      else    digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with enable, validated parallel load and terminal-count pulse.
// Define BCD_COUNTER_SATURATE_EN to hold at the limit instead of wrapping.
module bcd_updown_counter_n
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_1Hz,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  updown,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  localparam int unsigned CW = 4 * DIGITS;

  logic          load_ok_c;
  logic          limit_c;
  logic          step_ok_c;
  logic [DIGITS:0] carry;

  // A load is accepted only if every nibble is a legal BCD digit.
  always_comb begin
    load_ok_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) load_ok_c = 1'b0;
    end
  end

  // Carry out of the top digit is exactly the limit event.
  assign carry[0] = en & ~load;
  assign limit_c  = carry[DIGITS];

`ifdef BCD_COUNTER_SATURATE_EN
  assign step_ok_c = ~limit_c;
`else
  assign step_ok_c = 1'b1;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk_1Hz),
      .reset    (reset),
      .en       (step_ok_c),
      .up       (updown),
      .load     (load & load_ok_c),
      .ld_digit (load_val[4*g +: 4]),
      .cin      (carry[g]),
      .digit    (count[4*g +: 4]),
      .cout     (carry[g+1])
    );
  end

  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tc       <= limit_c;
      load_err <= load & ~load_ok_c;
    end
  end

  logic unused_cw;
  assign unused_cw = ^CW'(0);

endmodule
